javk_bus_arbiter: RTL and testbench
===================================

# javk_bus_arbiter

Sequences every external memory cycle of the JAVK CPU and shares the single 16-bit address / 8-bit data bus between two internal requesters: instruction fetch (read-only) and the load/store path (read/write). It owns `addrbus`, `rw` and the tristate drive of `databus`, inserts a fixed number of wait states, and returns read data with a one-cycle acknowledge pulse. Round-robin arbitration keeps either requester from starving the other.

## Interface
- `WAIT_STATES`, default 1: wait cycles per bus cycle, legal range 0..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `f_req`  in  1  fetch request; held high until `f_ack`.
- `f_addr`  in  16  fetch address.
- `f_ack`  out  1  one-cycle pulse; fetch cycle complete.
- `f_rdata`  out  8  fetch read data; valid while `f_ack`=1.
- `d_req`  in  1  data request; held high until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  16  data address.
- `d_wdata`  in  8  write data.
- `d_ack`  out  1  one-cycle pulse; data cycle complete.
- `d_rdata`  out  8  data read data; valid while `d_ack`=1 on a read.
- `addrbus`  out  16  external address.
- `rw`  out  1  1 = read, 0 = write.
- `databus`  inout  8  external data; driven only during write WAIT/XFER.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ADDR, WAIT, XFER, ACK.
- IDLE: sample `f_req`/`d_req`.
  - None high: stay in IDLE.
  - One high: grant it.
  - Both high: grant the port opposite the last-granted pointer.
  - On grant: latch owner, address, we (fetch forces we=0) and wdata; update the pointer; go to ADDR.
- ADDR: `addrbus` = latched address; `rw` = !we; `databus` still hi-Z (turnaround). Next state is WAIT if `WAIT_STATES`>0, else XFER.
- WAIT: load a 4-bit counter with `WAIT_STATES`-1 on entry and decrement; go to XFER when the counter reaches 0. On a write, drive `databus` = latched wdata.
- XFER:
  - Write: keep driving `databus`.
  - Read: register `databus` into the owner's rdata on the edge that ends XFER.
  - Next state: ACK.
- ACK: pulse the owner's ack for exactly one cycle. `rw` returns to 1, `databus` goes hi-Z, `addrbus` holds its last value. Requests are ignored. Next state: IDLE.
- Request latching: inputs are latched at grant. Later changes to addr/we/wdata, or dropping req mid-cycle (a protocol violation), do not alter the cycle, and ack is still issued.
- Non-owner rdata holds its previous value. The owner's rdata is unchanged on a write.
- `rw` and `addrbus` are driven straight from flops (glitch-free).
- Fetch requests with `d_we` high are irrelevant: the fetch port has no we.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-cycle):
  - state IDLE, pointer = "fetch last", so data wins the first tie.
  - `addrbus`=16'h0000, `rw`=1, `databus`=Z, `f_ack`=`d_ack`=0, `f_rdata`=`d_rdata`=8'h00, `busy`=0.
  - An interrupted cycle produces no ack.
- Latency: with cycle 0 = the IDLE cycle whose closing edge samples req, ack is high in cycle 3+`WAIT_STATES` (W=0: cycle 3; W=1: cycle 4).
- Throughput: one bus cycle every 4+`WAIT_STATES` clocks; IDLE always separates consecutive cycles.
- Handshake: a requester may hold req high through its ack cycle. A req still high in the following IDLE cycle is a new request.
- Write data on `databus` is stable from the first WAIT cycle (or XFER when W=0) through XFER, and hi-Z in ADDR and ACK. This gives one cycle of turnaround on each side.
- Back-to-back ties alternate grants F,D,F,D…; a single continuous requester gets every slot.

## Test plan
- Reset: assert `rst`=0 mid-write XFER -> `databus` Z, `rw`=1, `addrbus`=0000, `busy`=0 immediately; no ack after release.
- Fetch read, W=1: `f_addr`=1234, memory returns A5 -> `addrbus`=1234 with `rw`=1 from cycle 1; `f_ack`=1 and `f_rdata`=A5 in cycle 4 only.
- Data write, W=0: `d_addr`=FFF0, `d_wdata`=3C -> `rw`=0 in cycles 1-2; `databus`=3C only in cycle 2; `d_ack` in cycle 3.
- Contention: both reqs high continuously after reset -> grant order D,F,D,F; each ack spaced 5 clocks apart (W=1).
- Latch check: change `d_addr` and `d_wdata` one cycle after grant -> bus shows the original values; ack still issued once.
- W=15 read -> exactly 15 WAIT cycles; ack in cycle 18; `busy` high in cycles 1-18.

Source files
------------

// File: rtl/javk_bus_arbiter.sv
// javk_bus_arbiter: runs every external memory cycle of the JAVK CPU.
// Two requesters (instruction fetch, load/store) share one 16-bit address /
// 8-bit data bus. Each bus cycle is IDLE -> ADDR -> WAIT* -> XFER -> ACK.
// Ties between the requesters are broken round-robin.
module javk_bus_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic [7:0]  f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_ack,
    output logic [7:0]  d_rdata,
    output logic [15:0] addrbus,
    output logic        rw,
    inout  wire  [7:0]  databus,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_XFER,
        S_ACK
    } state_t;

    // Counter reload on WAIT entry; unused when there are no wait states.
    localparam logic [3:0] W_LOAD = 4'(WAIT_STATES - 1);
    localparam bit         W_ZERO = (WAIT_STATES == 0);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_grant_f;
    logic        w_grant_d;
    logic        r_owner_d;   // 1 = current cycle belongs to the data port
    logic        r_last_d;    // 1 = data port was granted most recently
    logic        r_we;
    logic [7:0]  r_wdata;
    logic [15:0] r_addr;
    logic        r_rw;
    logic        r_drive;
    logic [3:0]  r_cnt;
    logic [7:0]  r_f_rdata;
    logic [7:0]  r_d_rdata;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and arbitration (fetch wins a tie only if data went last)
    always_comb begin
        w_state_next = r_state;
        w_grant_f    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (f_req && (!d_req || r_last_d)) begin
                    w_grant_f    = 1'b1;
                    w_state_next = S_ADDR;
                end else if (d_req) begin
                    w_grant_d    = 1'b1;
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR:  w_state_next = W_ZERO ? S_XFER : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_next = S_XFER;
            S_XFER:  w_state_next = S_ACK;
            S_ACK:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Latch the winning request at grant; requester inputs are ignored afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_d <= 1'b0;
            r_last_d  <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= 8'h00;
            r_addr    <= 16'h0000;
        end else if (w_grant_f || w_grant_d) begin
            r_owner_d <= w_grant_d;
            r_last_d  <= w_grant_d;
            r_we      <= w_grant_d && d_we;
            r_wdata   <= d_wdata;
            r_addr    <= w_grant_d ? d_addr : f_addr;
        end
    end

    // Bus direction and write-data enable, both straight from flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rw    <= 1'b1;
            r_drive <= 1'b0;
        end else begin
            if (w_grant_f || w_grant_d) begin
                r_rw <= !(w_grant_d && d_we);
            end else if (r_state == S_XFER) begin
                r_rw <= 1'b1;
            end
            if (r_state == S_ADDR) begin
                r_drive <= r_we;
            end else if (r_state == S_XFER) begin
                r_drive <= 1'b0;
            end
        end
    end

    // Wait-state counter: reload leaving ADDR, count down while in WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_ADDR) begin
            r_cnt <= W_LOAD;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture read data into the owner's register on the edge ending XFER
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_f_rdata <= 8'h00;
            r_d_rdata <= 8'h00;
        end else if ((r_state == S_XFER) && !r_we) begin
            if (r_owner_d) begin
                r_d_rdata <= databus;
            end else begin
                r_f_rdata <= databus;
            end
        end
    end

    assign databus = r_drive ? r_wdata : 8'hzz;
    assign addrbus = r_addr;
    assign rw      = r_rw;
    assign busy    = (r_state != S_IDLE);
    assign f_ack   = (r_state == S_ACK) && !r_owner_d;
    assign d_ack   = (r_state == S_ACK) && r_owner_d;
    assign f_rdata = r_f_rdata;
    assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_javk_bus_arbiter.sv
// Testbench for javk_bus_arbiter: three instances (W=1, W=0, W=15) with a
// simple memory that drives databus whenever the bus reads.
module tb_javk_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A: WAIT_STATES = 1 ----------------
    logic        f_req_a = 0, d_req_a = 0, d_we_a = 0;
    logic [15:0] f_addr_a = 0, d_addr_a = 0;
    logic [7:0]  d_wdata_a = 0, mem_a = 0;
    logic        f_ack_a, d_ack_a, rw_a, busy_a;
    logic [7:0]  f_rdata_a, d_rdata_a;
    logic [15:0] addrbus_a;
    wire  [7:0]  db_a;
    assign db_a = (rw_a && busy_a) ? mem_a : 8'hzz;

    javk_bus_arbiter #(.WAIT_STATES(1)) u_a (
        .clk(clk), .rst(rst),
        .f_req(f_req_a), .f_addr(f_addr_a), .f_ack(f_ack_a), .f_rdata(f_rdata_a),
        .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
        .d_ack(d_ack_a), .d_rdata(d_rdata_a),
        .addrbus(addrbus_a), .rw(rw_a), .databus(db_a), .busy(busy_a)
    );

    // ---------------- instance B: WAIT_STATES = 0 ----------------
    logic        f_req_b = 0, d_req_b = 0, d_we_b = 0;
    logic [15:0] f_addr_b = 0, d_addr_b = 0;
    logic [7:0]  d_wdata_b = 0;
    logic        f_ack_b, d_ack_b, rw_b, busy_b;
    logic [7:0]  f_rdata_b, d_rdata_b;
    logic [15:0] addrbus_b;
    wire  [7:0]  db_b;
    assign db_b = (rw_b && busy_b) ? 8'h00 : 8'hzz;

    javk_bus_arbiter #(.WAIT_STATES(0)) u_b (
        .clk(clk), .rst(rst),
        .f_req(f_req_b), .f_addr(f_addr_b), .f_ack(f_ack_b), .f_rdata(f_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_ack(d_ack_b), .d_rdata(d_rdata_b),
        .addrbus(addrbus_b), .rw(rw_b), .databus(db_b), .busy(busy_b)
    );

    // ---------------- instance C: WAIT_STATES = 15 ----------------
    logic        f_req_c = 0, d_req_c = 0, d_we_c = 0;
    logic [15:0] f_addr_c = 0, d_addr_c = 0;
    logic [7:0]  d_wdata_c = 0, mem_c = 0;
    logic        f_ack_c, d_ack_c, rw_c, busy_c;
    logic [7:0]  f_rdata_c, d_rdata_c;
    logic [15:0] addrbus_c;
    wire  [7:0]  db_c;
    assign db_c = (rw_c && busy_c) ? mem_c : 8'hzz;

    javk_bus_arbiter #(.WAIT_STATES(15)) u_c (
        .clk(clk), .rst(rst),
        .f_req(f_req_c), .f_addr(f_addr_c), .f_ack(f_ack_c), .f_rdata(f_rdata_c),
        .d_req(d_req_c), .d_we(d_we_c), .d_addr(d_addr_c), .d_wdata(d_wdata_c),
        .d_ack(d_ack_c), .d_rdata(d_rdata_c),
        .addrbus(addrbus_c), .rw(rw_c), .databus(db_c), .busy(busy_c)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // databus must not carry the given write value (hi-Z or memory data instead)
    task automatic chk_ne(input string name, input logic [7:0] act, input logic [7:0] bad);
        n_checks++;
        if (act === bad) begin
            n_errors++;
            $display("FAIL %s: got %h, must not be driven with %h", name, act, bad);
        end
    endtask

    // One record per clock cycle on instance A: inputs applied at cycle start,
    // outputs compared mid-cycle. db_mode: 0 = skip, 1 = equal, 2 = not equal.
    typedef struct {
        logic        f_req;
        logic [15:0] f_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [7:0]  d_wdata;
        logic [7:0]  mem;
        logic [15:0] e_addr;
        logic        e_rw;
        logic        e_busy;
        logic        e_fack;
        logic        e_dack;
        logic [7:0]  e_frd;
        logic [7:0]  e_drd;
        logic [1:0]  db_mode;
        logic [7:0]  e_db;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int   ack_n;
        int   ack_cyc[4];
        logic ack_own[4];   // 1 = data
        int   n_busy;
        int   c_ack;
        int   k;

        // fetch read 1234 -> A5 (address changes after grant must not matter)
        vecs[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hA5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 8'h00};
        vecs[1]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hA5, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 8'hA5};
        vecs[2]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hA5, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 8'h00};
        vecs[3]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hA5, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 8'h00};
        vecs[4]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hA5, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 8'h00, 2'd0, 8'h00};
        vecs[5]  = '{1'b0, 16'h5555, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hA5, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd0, 8'h00};
        // data write 4000 <- 5A; addr/wdata/we change after grant, req dropped in XFER
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h4000, 8'h5A, 8'hA5, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd0, 8'h00};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h4FFF, 8'hFF, 8'hA5, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd2, 8'h5A};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h4FFF, 8'hFF, 8'hA5, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd1, 8'h5A};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h4FFF, 8'hFF, 8'hA5, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd1, 8'h5A};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h4FFF, 8'hFF, 8'hA5, 16'h4000, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h00, 2'd2, 8'h5A};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h4FFF, 8'hFF, 8'hA5, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd2, 8'h5A};
        // data read 0200 -> 77; fetch rdata must hold A5
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h77, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd0, 8'h00};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h77, 16'h0200, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd1, 8'h77};
        vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h77, 16'h0200, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd0, 8'h00};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h77, 16'h0200, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 2'd0, 8'h00};
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h77, 16'h0200, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h77, 2'd0, 8'h00};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0200, 8'h00, 8'h77, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h77, 2'd0, 8'h00};

        // reset values
        @(negedge clk);
        chk("reset addrbus", addrbus_a, 16'h0000);
        chk("reset rw", rw_a, 1'b1);
        chk("reset busy", busy_a, 1'b0);
        chk("reset f_ack", f_ack_a, 1'b0);
        chk("reset d_ack", d_ack_a, 1'b0);
        chk("reset f_rdata", f_rdata_a, 8'h00);
        chk("reset d_rdata", d_rdata_a, 8'h00);
        chk("reset busy W0", busy_b, 1'b0);
        chk("reset busy W15", busy_c, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        // table-driven cycles on instance A
        for (int i = 0; i < 18; i++) begin
            f_req_a   = vecs[i].f_req;
            f_addr_a  = vecs[i].f_addr;
            d_req_a   = vecs[i].d_req;
            d_we_a    = vecs[i].d_we;
            d_addr_a  = vecs[i].d_addr;
            d_wdata_a = vecs[i].d_wdata;
            mem_a     = vecs[i].mem;
            @(negedge clk);
            $display("row %0d: addrbus=%h rw=%b busy=%b f_ack=%b d_ack=%b f_rdata=%h d_rdata=%h databus=%h",
                     i, addrbus_a, rw_a, busy_a, f_ack_a, d_ack_a, f_rdata_a, d_rdata_a, db_a);
            chk($sformatf("row%0d addrbus", i), addrbus_a, vecs[i].e_addr);
            chk($sformatf("row%0d rw", i), rw_a, vecs[i].e_rw);
            chk($sformatf("row%0d busy", i), busy_a, vecs[i].e_busy);
            chk($sformatf("row%0d f_ack", i), f_ack_a, vecs[i].e_fack);
            chk($sformatf("row%0d d_ack", i), d_ack_a, vecs[i].e_dack);
            chk($sformatf("row%0d f_rdata", i), f_rdata_a, vecs[i].e_frd);
            chk($sformatf("row%0d d_rdata", i), d_rdata_a, vecs[i].e_drd);
            if (vecs[i].db_mode == 2'd1) chk($sformatf("row%0d databus", i), db_a, vecs[i].e_db);
            if (vecs[i].db_mode == 2'd2) chk_ne($sformatf("row%0d databus hiz", i), db_a, vecs[i].e_db);
            @(posedge clk); #1;
        end

        // data write W=0: FFF0 <- 3C
        d_req_b = 1'b1; d_we_b = 1'b1; d_addr_b = 16'hFFF0; d_wdata_b = 8'h3C;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            $display("W0 write cycle %0d: addrbus=%h rw=%b busy=%b d_ack=%b databus=%h",
                     c, addrbus_b, rw_b, busy_b, d_ack_b, db_b);
            chk($sformatf("w0 c%0d rw", c), rw_b, (c == 1 || c == 2) ? 1'b0 : 1'b1);
            chk($sformatf("w0 c%0d busy", c), busy_b, (c >= 1 && c <= 3) ? 1'b1 : 1'b0);
            chk($sformatf("w0 c%0d d_ack", c), d_ack_b, (c == 3) ? 1'b1 : 1'b0);
            chk($sformatf("w0 c%0d addrbus", c), addrbus_b, (c >= 1) ? 16'hFFF0 : 16'h0000);
            if (c == 2) chk("w0 c2 databus", db_b, 8'h3C);
            else        chk_ne($sformatf("w0 c%0d databus hiz", c), db_b, 8'h3C);
            if (c == 3) d_req_b = 1'b0;
            @(posedge clk); #1;
        end

        // contention on W=1 after a fresh reset: D,F,D,F, 5 clocks apart
        rst = 1'b0; #1; rst = 1'b1;
        f_req_a = 1'b1; d_req_a = 1'b1; d_we_a = 1'b0;
        f_addr_a = 16'hAAAA; d_addr_a = 16'hDDDD; mem_a = 8'h99;
        ack_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (f_ack_a && d_ack_a) chk("contention both acks", {f_ack_a, d_ack_a}, 2'b01);
            if ((f_ack_a || d_ack_a) && ack_n < 4) begin
                $display("contention ack %0d: cycle %0d owner=%s", ack_n, c, d_ack_a ? "D" : "F");
                ack_cyc[ack_n] = c;
                ack_own[ack_n] = d_ack_a;
                ack_n++;
            end
            if (c == 39) begin
                f_req_a = 1'b0; d_req_a = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("contention ack count", ack_n[15:0], 16'd4);
        for (int i = 0; i < 4 && i < ack_n; i++) begin
            chk($sformatf("contention ack%0d owner", i), ack_own[i], (i % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("contention ack%0d cycle", i), ack_cyc[i][15:0], 16'(4 + 5 * i));
        end
        k = 0;
        @(negedge clk);
        while (busy_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("contention drains to idle", busy_a, 1'b0);
        chk("contention f_rdata", f_rdata_a, 8'h99);
        chk("contention d_rdata", d_rdata_a, 8'h99);
        @(posedge clk); #1;

        // W=15 fetch read: 15 wait cycles, ack in cycle 18, busy in cycles 1-18
        f_req_c = 1'b1; f_addr_c = 16'h0F0F; mem_c = 8'h5E;
        n_busy = 0; c_ack = -1; ack_n = 0;
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            if (busy_c) begin
                n_busy++;
                if (c < 1 || c > 18) chk($sformatf("w15 busy c%0d", c), busy_c, 1'b0);
            end
            if (f_ack_c) begin
                ack_n++;
                c_ack = c;
                f_req_c = 1'b0;
                $display("W15 read: f_ack in cycle %0d, f_rdata=%h addrbus=%h", c, f_rdata_c, addrbus_c);
                chk("w15 f_rdata", f_rdata_c, 8'h5E);
                chk("w15 addrbus", addrbus_c, 16'h0F0F);
            end
            @(posedge clk); #1;
        end
        chk("w15 ack count", ack_n[15:0], 16'd1);
        chk("w15 ack cycle", c_ack[15:0], 16'd18);
        chk("w15 busy cycles", n_busy[15:0], 16'd18);

        // reset during a write XFER on W=1
        d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 16'h0BEE; d_wdata_a = 8'h3C;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("pre-reset XFER databus", db_a, 8'h3C);
        chk("pre-reset XFER rw", rw_a, 1'b0);
        d_req_a = 1'b0;
        #1 rst = 1'b0;
        #1;
        $display("mid-XFER reset: addrbus=%h rw=%b busy=%b databus=%h", addrbus_a, rw_a, busy_a, db_a);
        chk_ne("reset databus hiz", db_a, 8'h3C);
        chk("reset mid rw", rw_a, 1'b1);
        chk("reset mid addrbus", addrbus_a, 16'h0000);
        chk("reset mid busy", busy_a, 1'b0);
        chk("reset mid d_rdata", d_rdata_a, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        ack_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (d_ack_a || f_ack_a) ack_n++;
        end
        chk("no ack after reset", ack_n[15:0], 16'd0);
        chk("idle after reset", busy_a, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // overall time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

endmodule
